// File: rtl/shared_resource_lock_scheduler.sv
// Locked round-robin ownership of one shared resource among N requesters; optional hold limit via ARB_HOLD_TIMEOUT_EN.
// Latency: request seen in IDLE/GAP is granted on the next edge; handover between owners costs exactly one grant-low cycle.
// Backpressure: none; requests wait by level while another owner holds, and release pulses from non-owners are ignored.
module shared_resource_lock_scheduler #(
    parameter  int N        = 8,
    parameter  int MAX_HOLD = 16,
    localparam int IDW      = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   release_pulse,
    output logic [N-1:0]   grant,
    output logic           grant_valid,
    output logic [IDW-1:0] grant_id,
    output logic           timeout_pulse
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        GAP  = 2'd2
    } state_t;

    if (N < 2 || MAX_HOLD < 2) begin : g_param_check
        $error("shared_resource_lock_scheduler: N and MAX_HOLD must both be >= 2");
    end

    state_t         state, state_nxt;
    logic [N-1:0]   grant_nxt;
    logic [IDW-1:0] grant_id_nxt;
    logic [IDW-1:0] ptr, ptr_nxt;
    logic           win_found;
    logic [IDW-1:0] win_id;
    logic           owner_done;
    logic           exit_own;
    int             scan_idx;

`ifdef ARB_HOLD_TIMEOUT_EN
    localparam int HCW = $clog2(MAX_HOLD + 1);
    logic [HCW-1:0] hold_cnt, hold_cnt_nxt;
    logic           timeout_nxt;
`endif

    // Round-robin search starting at ptr and wrapping past N-1.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        scan_idx  = 0;
        for (int i = 0; i < N; i++) begin
            scan_idx = int'(ptr) + i;
            if (scan_idx >= N) begin
                scan_idx = scan_idx - N;
            end
            if (!win_found && req[IDW'(scan_idx)]) begin
                win_found = 1'b1;
                win_id    = IDW'(scan_idx);
            end
        end
    end

    assign owner_done = release_pulse[grant_id] | ~req[grant_id];

    always_comb begin
        state_nxt    = state;
        grant_nxt    = grant;
        grant_id_nxt = grant_id;
        ptr_nxt      = ptr;
        exit_own     = 1'b0;
`ifdef ARB_HOLD_TIMEOUT_EN
        hold_cnt_nxt = hold_cnt;
        timeout_nxt  = 1'b0;
`endif
        case (state)
            IDLE, GAP: begin
                state_nxt = IDLE;
                grant_nxt = '0;
                if (win_found) begin
                    state_nxt    = OWN;
                    grant_nxt    = {{(N-1){1'b0}}, 1'b1} << win_id;
                    grant_id_nxt = win_id;
`ifdef ARB_HOLD_TIMEOUT_EN
                    hold_cnt_nxt = '0;
`endif
                end
            end
            OWN: begin
`ifdef ARB_HOLD_TIMEOUT_EN
                hold_cnt_nxt = hold_cnt + 1'b1;
`endif
                if (owner_done) begin
                    exit_own = 1'b1;
                end
`ifdef ARB_HOLD_TIMEOUT_EN
                // A voluntary exit in the same cycle wins over the forced one.
                else if (hold_cnt == HCW'(MAX_HOLD - 1)) begin
                    exit_own    = 1'b1;
                    timeout_nxt = 1'b1;
                end
`endif
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
            end
        endcase

        if (exit_own) begin
            state_nxt = GAP;
            grant_nxt = '0;
            ptr_nxt   = (grant_id == IDW'(N - 1)) ? '0 : grant_id + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            ptr         <= '0;
        end else begin
            state       <= state_nxt;
            grant       <= grant_nxt;
            grant_valid <= |grant_nxt;
            grant_id    <= grant_id_nxt;
            ptr         <= ptr_nxt;
        end
    end

`ifdef ARB_HOLD_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt      <= '0;
            timeout_pulse <= 1'b0;
        end else begin
            hold_cnt      <= hold_cnt_nxt;
            timeout_pulse <= timeout_nxt;
        end
    end
`else
    assign timeout_pulse = 1'b0;
`endif

endmodule
